// File: rtl/fifo_pkg.sv
// Shared defaults and types for the synchronous byte FIFO.
// The modules take their parameter defaults from here; the typedefs match those defaults.
package fifo_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

    typedef logic [DEF_DATA_W-1:0] data_t;
    typedef logic [DEF_ADDR_W:0]   ptr_t;
endpackage

// File: rtl/sync_fifo_core_mem.sv
// Simple dual-port register array with a registered read port.
// The array itself has no reset; only the read register is cleared.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read data holds its value between accepted reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_core.sv
// Synchronous FIFO control: pointers, occupancy count, full/empty flags and
// sticky overflow/underflow errors around a registered-read storage array.
module sync_fifo_core
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_enb,
    input  logic              read,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] count_next;
    logic            wr_acc;
    logic            rd_acc;

    // Accept decisions use the flags registered before this edge.
    always_comb begin
        wr_acc     = write_enb & ~full;
        rd_acc     = read & ~empty;
        count_next = count + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == '0);
        end
    end

    // clr_err wins over any error event on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (write_enb & full);
            underflow <= underflow | (read & empty);
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (data_out)
    );

    // The count-based flags must agree with the wrap-bit pointer comparison.
    logic ptr_full;
    logic ptr_empty;
    logic [ADDR_W:0] ptr_diff;

    always_comb begin
        ptr_full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
        ptr_empty = (wr_ptr == rd_ptr);
        ptr_diff  = wr_ptr - rd_ptr;
    end

    a_flags_agree: assert property (@(posedge clk) disable iff (!reset)
        (full == ptr_full) && (empty == ptr_empty) && (count == ptr_diff));

endmodule
